hdmi_mode_sequencer: RTL and testbench

Sequences glitch-free NTSC/PAL switching of the dual-timing HDMI output stage: accepts a requested video standard from the VDP register file and applies it only at a frame boundary. Blanks video, optionally mutes audio, and holds the HDMI encoders and serializer in reset for a fixed window around the switch. Sits between the VDP control logic and `hdmi_selection`, driving its `pal_mode`, `reset`, `include_audio` and an RGB blank gate.

---
 rtl/hdmi_mode_sequencer_pkg.sv | 22 ++
 rtl/hdmi_mode_sequencer_if.sv | 24 ++
 rtl/hdmi_mode_sequencer_frame_event_timer.sv | 47 ++++
 rtl/hdmi_mode_sequencer.sv | 123 ++++++++++++
 tb/tb_hdmi_mode_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_mode_sequencer_pkg.sv
// Shared types and constants for the HDMI NTSC/PAL mode sequencer.
package hdmi_mode_pkg;

  typedef enum logic [1:0] {
    RST_HOLD   = 2'd0,
    POST_BLANK = 2'd1,
    IDLE       = 2'd2,
    PRE_BLANK  = 2'd3
  } hdmi_mode_state_t;

  localparam logic HDMI_MODE_NTSC = 1'b0;
  localparam logic HDMI_MODE_PAL  = 1'b1;

  // CEA-861 VIC codes that hdmi_selection programs for each standard.
  localparam logic [6:0] HDMI_VIC_NTSC = 7'd2;
  localparam logic [6:0] HDMI_VIC_PAL  = 7'd17;

  function automatic logic [6:0] vic_for_mode(input logic pal);
    return pal ? HDMI_VIC_PAL : HDMI_VIC_NTSC;
  endfunction

endpackage

// File: rtl/hdmi_mode_sequencer_if.sv
// Control/status bundle between VDP control logic, the mode sequencer and hdmi_selection.
interface hdmi_mode_sequencer_if;

  logic        pal_mode_req;
  logic        include_audio_req;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic        pal_mode;
  logic        hdmi_reset;
  logic        blank;
  logic        include_audio;
  logic        busy;

  modport master (
    input  pal_mode_req, include_audio_req, cx, cy,
    output pal_mode, hdmi_reset, blank, include_audio, busy
  );

  modport slave (
    output pal_mode_req, include_audio_req, cx, cy,
    input  pal_mode, hdmi_reset, blank, include_audio, busy
  );

endinterface

// File: rtl/hdmi_mode_sequencer_frame_event_timer.sv
// Frame-boundary edge detector merged with a saturating watchdog; emits one
// frame_evt pulse per boundary or per timeout expiry.
module frame_event_timer
  import hdmi_mode_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        clear,
  input  logic [10:0] cx,
  input  logic [9:0]  cy,
  output logic        frame_evt
);

  localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TO_MAX = TW'(TIMEOUT_CYCLES);

  logic          origin;
  logic          origin_q;
  logic          fb;
  logic          expired;
  logic [TW-1:0] to_cnt_q;

  assign origin    = (cx == 11'd0) && (cy == 10'd0);
  assign fb        = origin & ~origin_q;
  assign expired   = (to_cnt_q == TO_MAX);
  // A boundary landing on the expiry cycle yields a single event.
  assign frame_evt = fb | expired;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      origin_q <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      origin_q <= origin;
      if (clear || frame_evt) begin
        to_cnt_q <= '0;
      end else if (!expired) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdmi_mode_sequencer.sv
// Applies NTSC/PAL changes at frame boundaries with blanking and an encoder reset window.
// Optional feature: define HDMI_MODE_AUDIO_MUTE_EN to mute audio while busy.
module hdmi_mode_sequencer
  import hdmi_mode_pkg::*;
#(
  parameter int RESET_CYCLES   = 16,
  parameter int BLANK_FRAMES   = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  hdmi_mode_sequencer_if.master bus
);

  localparam int            RW       = $clog2(RESET_CYCLES + 1);
  localparam int            FW       = $clog2(BLANK_FRAMES + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLANK_FRAMES - 1);

  hdmi_mode_state_t state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [FW-1:0]    frm_cnt_q, frm_cnt_d;
  logic             pal_q, pal_d;
  logic             timer_clear;
  logic             frame_evt;
  logic             busy_d;
  logic             audio_d;
  logic             hdmi_reset_q, blank_q, busy_q, audio_q;

  frame_event_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .clear     (timer_clear),
    .cx        (bus.cx),
    .cy        (bus.cy),
    .frame_evt (frame_evt)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    frm_cnt_d   = frm_cnt_q;
    pal_d       = pal_q;
    timer_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.pal_mode_req != pal_q) begin
          state_d     = PRE_BLANK;
          timer_clear = 1'b1;
        end
      end
      PRE_BLANK: begin
        // The request is re-sampled here; a reverted request still runs the window.
        if (frame_evt) begin
          state_d   = RST_HOLD;
          pal_d     = bus.pal_mode_req;
          rst_cnt_d = '0;
        end
      end
      RST_HOLD: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d     = POST_BLANK;
          frm_cnt_d   = '0;
          timer_clear = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      POST_BLANK: begin
        if (frame_evt) begin
          if (frm_cnt_q == FRM_LAST) begin
            state_d = IDLE;
          end else begin
            frm_cnt_d = frm_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RST_HOLD;
    endcase
  end

  // Outputs are decoded from the next state so they are valid in the first cycle of it.
  assign busy_d = (state_d != IDLE);

`ifdef HDMI_MODE_AUDIO_MUTE_EN
  assign audio_d = bus.include_audio_req & ~busy_d;
`else
  assign audio_d = bus.include_audio_req;
`endif

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q      <= RST_HOLD;
      rst_cnt_q    <= '0;
      frm_cnt_q    <= '0;
      pal_q        <= HDMI_MODE_NTSC;
      hdmi_reset_q <= 1'b1;
      blank_q      <= 1'b1;
      busy_q       <= 1'b1;
      audio_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
      pal_q        <= pal_d;
      hdmi_reset_q <= (state_d == RST_HOLD);
      blank_q      <= busy_d;
      busy_q       <= busy_d;
      audio_q      <= audio_d;
    end
  end

  assign bus.pal_mode      = pal_q;
  assign bus.hdmi_reset    = hdmi_reset_q;
  assign bus.blank         = blank_q;
  assign bus.busy          = busy_q;
  assign bus.include_audio = audio_q;

endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// Self-checking bench for hdmi_mode_sequencer: per-cycle scoreboard plus directed
// timing sequences on a 10x5 (50-cycle) frame model.
module tb_hdmi_mode_sequencer;
  import hdmi_mode_pkg::*;

  localparam int RC = 4;
  localparam int BF = 2;
  localparam int TO = 100;
`ifdef HDMI_MODE_AUDIO_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  typedef struct packed {
    logic pal;
    logic hrst;
    logic blank;
    logic busy;
    logic aud;
  } outs_t;

  typedef struct {
    logic  rst;
    logic  pal_req;
    logic  aud_req;
    outs_t exp;
  } vec_t;

  logic clk_pixel = 1'b0;
  logic reset;
  hdmi_mode_sequencer_if bus ();

  hdmi_mode_sequencer #(
    .RESET_CYCLES   (RC),
    .BLANK_FRAMES   (BF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    pos = 0;
  bit    freeze = 1'b0;
  bit    rst_i, pal_req_i, aud_req_i;
  bit    audio_mon = 1'b0;
  int    aud_bad = 0;
  outs_t sb_q[$];
  vec_t  vt[7];

  // Reference model state: 0=RST_HOLD 1=POST_BLANK 2=IDLE 3=PRE_BLANK
  int m_st, m_rc, m_fc, m_to;
  bit m_mq, m_pal, m_aud;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic outs_t outs_now();
    return {bus.pal_mode, bus.hdmi_reset, bus.blank, bus.busy, bus.include_audio};
  endfunction

  task automatic model_edge();
    bit match, fb, evt, clr;
    if (rst_i) begin
      m_st = 0; m_rc = 0; m_fc = 0; m_to = 0; m_mq = 0; m_pal = 0; m_aud = 0;
    end else begin
      match = (pos == 0);
      fb    = match && !m_mq;
      evt   = fb || (m_to >= TO);
      m_mq  = match;
      clr   = 1'b0;
      case (m_st)
        2: if (pal_req_i != m_pal) begin m_st = 3; clr = 1'b1; end
        3: if (evt) begin m_st = 0; m_pal = pal_req_i; m_rc = 0; end
        0: if (m_rc == RC - 1) begin m_st = 1; m_fc = 0; clr = 1'b1; end
           else m_rc++;
        default: if (evt) begin m_fc++; if (m_fc == BF) m_st = 2; end
      endcase
      if (clr || evt) m_to = 0;
      else if (m_to < TO) m_to++;
      m_aud = MUTE ? (aud_req_i && (m_st == 2)) : aud_req_i;
    end
    sb_q.push_back({m_pal, (m_st == 0), (m_st != 2), (m_st != 2), m_aud});
  endtask

  // Drive one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step();
    outs_t e;
    reset                 = rst_i;
    bus.pal_mode_req      = pal_req_i;
    bus.include_audio_req = aud_req_i;
    bus.cx                = 11'(pos % 10);
    bus.cy                = 10'(pos / 10);
    model_edge();
    @(posedge clk_pixel);
    #1;
    cyc++;
    e = sb_q.pop_front();
    check($sformatf("scoreboard@%0d", cyc), int'(outs_now()), int'(e));
    if (audio_mon && (bus.include_audio !== (MUTE ? !bus.busy : 1'b1))) aud_bad++;
    if (!freeze) pos = (pos + 1) % 50;
  endtask

  task automatic apply_vec(input int i);
    rst_i     = vt[i].rst;
    pal_req_i = vt[i].pal_req;
    aud_req_i = vt[i].aud_req;
    step();
    check($sformatf("table[%0d]", i), int'(outs_now()), int'(vt[i].exp));
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (pos != p && n < 100) begin step(); n++; end
    if (pos != p) check("wait_pos bound", pos, p);
  endtask

  task automatic wait_hrst(input string nm);
    int n = 0;
    while (!bus.hdmi_reset && n < 300) begin step(); n++; end
    if (!bus.hdmi_reset) check({nm, " reset-entry bound"}, 0, 1);
  endtask

  task automatic count_hrst(output int hr);
    int n = 0;
    hr = bus.hdmi_reset ? 1 : 0;
    while (bus.hdmi_reset && n < 50) begin
      step(); n++;
      if (bus.hdmi_reset) hr++;
    end
  endtask

  task automatic count_post(output int fbs, output int cycles);
    int drv;
    bit fz;
    fbs = 0;
    cycles = 0;
    for (int n = 0; n < 1000; n++) begin
      if (!bus.busy) break;
      cycles++;
      drv = pos;
      fz  = freeze;
      step();
      if (drv == 0 && !fz) fbs++;
    end
    if (bus.busy) check("post-blank bound", 0, 1);
  endtask

  initial begin
    int hr, fbs, pc, pre, n;
    vt[0] = '{1'b1, 1'b0, 1'b1, 5'b01110};
    vt[1] = '{1'b1, 1'b0, 1'b1, 5'b01110};
    vt[2] = '{1'b1, 1'b0, 1'b1, 5'b01110};
    vt[3] = '{1'b0, 1'b0, 1'b0, 5'b00000};
    vt[4] = '{1'b0, 1'b0, 1'b1, 5'b00001};
    vt[5] = '{1'b0, 1'b0, 1'b0, 5'b00000};
    vt[6] = '{1'b0, 1'b0, 1'b1, 5'b00001};

    // Power-up: 3 reset cycles, then the full hold/blank sequence.
    for (int i = 0; i < 3; i++) apply_vec(i);
    rst_i = 1'b0;
    count_hrst(hr);
    check("powerup hdmi_reset cycles", hr, RC);
    count_post(fbs, pc);
    check("powerup blank frames", fbs, BF);
    check("powerup pal_mode", bus.pal_mode, 0);
    check("powerup blank", bus.blank, 0);

    // IDLE: audio request follows with one cycle of latency.
    for (int i = 3; i < 7; i++) apply_vec(i);
    audio_mon = 1'b1;

    // Request PAL at cx=5,cy=2.
    wait_pos(25);
    pal_req_i = 1'b1;
    step();
    check("request to blank", bus.blank, 1);
    n = 0;
    while (pos != 0 && n < 60) begin step(); n++; end
    check("pal_mode before fb", bus.pal_mode, 0);
    step();
    check("pal_mode after fb", bus.pal_mode, 1);
    check("hdmi_reset after fb", bus.hdmi_reset, 1);
    count_hrst(hr);
    check("switch hdmi_reset cycles", hr, RC);
    count_post(fbs, pc);
    check("switch blank frames", fbs, BF);

    // Frozen raster: every boundary wait is ended by the timeout.
    wait_pos(33);
    freeze    = 1'b1;
    pal_req_i = 1'b0;
    step();
    pre = (bus.blank && !bus.hdmi_reset) ? 1 : 0;
    n = 0;
    while (!bus.hdmi_reset && n < 300) begin
      step(); n++;
      if (!bus.hdmi_reset) pre++;
    end
    check("timeout pre-blank cycles", pre, TO + 1);
    count_hrst(hr);
    check("timeout hdmi_reset cycles", hr, RC);
    count_post(fbs, pc);
    check("timeout post-blank cycles", pc, 2 * (TO + 1));
    check("timeout pal_mode", bus.pal_mode, 0);
    freeze = 1'b0;

    // Request reverts during RST_HOLD: applied mode holds, then IDLE restarts.
    pal_req_i = 1'b1;
    wait_hrst("toggle");
    pal_req_i = 1'b0;
    count_hrst(hr);
    check("toggle pal_mode in post-blank", bus.pal_mode, 1);
    count_post(fbs, pc);
    check("toggle pal_mode at idle", bus.pal_mode, 1);
    check("toggle idle busy", bus.busy, 0);
    step();
    check("toggle restart busy", bus.busy, 1);
    wait_hrst("restart");
    count_hrst(hr);
    count_post(fbs, pc);
    check("restart pal_mode", bus.pal_mode, 0);

    // Reset mid POST_BLANK.
    audio_mon = 1'b0;
    pal_req_i = 1'b1;
    wait_hrst("midreset");
    count_hrst(hr);
    repeat (5) step();
    rst_i = 1'b1;
    step();
    check("mid-post reset outputs", int'(outs_now()), int'(5'b01110));
    rst_i = 1'b0;
    count_hrst(hr);
    check("mid-post reset hdmi_reset cycles", hr, RC);
    check("mid-post reset pal_mode", bus.pal_mode, 0);
    count_post(fbs, pc);
    check("mid-post reset blank frames", fbs, BF);
    wait_hrst("post-reset restart");
    count_hrst(hr);
    count_post(fbs, pc);
    check("post-reset restart pal_mode", bus.pal_mode, 1);

    check("audio gating vs busy", aud_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
